// File: rtl/acq_sequencer.sv
// GPS acquisition search controller: sweeps PRN x Doppler bin x code phase,
// one correlator dump per cell, reporting the first detection or the strongest cell.
module acq_sequencer #(
  parameter int unsigned      FCW_W       = 24,
  parameter logic [FCW_W-1:0] FCW_CENTER  = 24'h100000,
  parameter logic [FCW_W-1:0] FCW_STEP    = 24'h000800,
  parameter int unsigned      N_BINS      = 5,
  parameter int unsigned      MAG_W       = 16,
  parameter logic [31:0]      TIMEOUT_CYC = 32'd100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [5:0]       prn_first,
  input  logic [5:0]       prn_last,
  input  logic [MAG_W-1:0] threshold,
  input  logic             corr_valid,
  input  logic [MAG_W-1:0] corr_mag,
  output logic [3:0]       cagen_t0,
  output logic [3:0]       cagen_t1,
  output logic             cagen_rst,
  output logic             cagen_slip,
  output logic [FCW_W-1:0] nco_fcw,
  output logic             nco_rst,
  output logic             corr_clr,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [5:0]       res_prn,
  output logic [3:0]       res_bin,
  output logic [9:0]       res_phase,
  output logic [MAG_W-1:0] res_mag
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_WAIT, S_EVAL, S_STEP, S_DONE
  } state_t;

  localparam logic [3:0]  LAST_BIN = 4'(N_BINS - 1);
  localparam int unsigned HALF     = (N_BINS - 1) / 2;

  state_t           state;
  logic [5:0]       prn, prn_last_r, best_prn;
  logic [3:0]       bin, best_bin;
  logic [9:0]       phase, best_phase;
  logic [MAG_W-1:0] thr_r, mag_r, best_mag;
  logic [31:0]      cnt;
  logic             range_ok;

  // G2 phase-selector taps {t0, t1}, 1-based stage numbers
  function automatic logic [7:0] tap_of(input logic [5:0] p);
    case (p)
      6'd1:  tap_of = {4'd2, 4'd6};   6'd2:  tap_of = {4'd3, 4'd7};
      6'd3:  tap_of = {4'd4, 4'd8};   6'd4:  tap_of = {4'd5, 4'd9};
      6'd5:  tap_of = {4'd1, 4'd9};   6'd6:  tap_of = {4'd2, 4'd10};
      6'd7:  tap_of = {4'd1, 4'd8};   6'd8:  tap_of = {4'd2, 4'd9};
      6'd9:  tap_of = {4'd3, 4'd10};  6'd10: tap_of = {4'd2, 4'd3};
      6'd11: tap_of = {4'd3, 4'd4};   6'd12: tap_of = {4'd5, 4'd6};
      6'd13: tap_of = {4'd6, 4'd7};   6'd14: tap_of = {4'd7, 4'd8};
      6'd15: tap_of = {4'd8, 4'd9};   6'd16: tap_of = {4'd9, 4'd10};
      6'd17: tap_of = {4'd1, 4'd4};   6'd18: tap_of = {4'd2, 4'd5};
      6'd19: tap_of = {4'd3, 4'd6};   6'd20: tap_of = {4'd4, 4'd7};
      6'd21: tap_of = {4'd5, 4'd8};   6'd22: tap_of = {4'd6, 4'd9};
      6'd23: tap_of = {4'd1, 4'd3};   6'd24: tap_of = {4'd4, 4'd6};
      6'd25: tap_of = {4'd5, 4'd7};   6'd26: tap_of = {4'd6, 4'd8};
      6'd27: tap_of = {4'd7, 4'd9};   6'd28: tap_of = {4'd8, 4'd10};
      6'd29: tap_of = {4'd1, 4'd6};   6'd30: tap_of = {4'd2, 4'd7};
      6'd31: tap_of = {4'd3, 4'd8};   6'd32: tap_of = {4'd4, 4'd9};
      default: tap_of = '0;
    endcase
  endfunction

  // Bin offset from centre is signed; computing modulo 2^FCW_W lets it wrap.
  function automatic logic [FCW_W-1:0] fcw_of(input logic [3:0] b);
    fcw_of = FCW_CENTER + FCW_STEP * FCW_W'(b) - FCW_STEP * FCW_W'(HALF);
  endfunction

  assign range_ok = (prn_first != 6'd0) && (prn_first <= 6'd32) &&
                    (prn_last <= 6'd32) && (prn_first <= prn_last);
  assign busy = (state != S_IDLE);

  // Taps, fcw and the config pulses are loaded on the edge that enters CONFIG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      prn        <= '0;
      prn_last_r <= '0;
      bin        <= '0;
      phase      <= '0;
      thr_r      <= '0;
      mag_r      <= '0;
      cnt        <= '0;
      best_prn   <= '0;
      best_bin   <= '0;
      best_phase <= '0;
      best_mag   <= '0;
      cagen_t0   <= '0;
      cagen_t1   <= '0;
      nco_fcw    <= '0;
      cagen_rst  <= 1'b0;
      cagen_slip <= 1'b0;
      nco_rst    <= 1'b0;
      corr_clr   <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      err        <= 1'b0;
      res_prn    <= '0;
      res_bin    <= '0;
      res_phase  <= '0;
      res_mag    <= '0;
    end else begin
      cagen_rst  <= 1'b0;
      cagen_slip <= 1'b0;
      nco_rst    <= 1'b0;
      corr_clr   <= 1'b0;
      done       <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            found <= 1'b0;
            if (range_ok) begin
              err                  <= 1'b0;
              prn_last_r           <= prn_last;
              thr_r                <= threshold;
              best_prn             <= '0;
              best_bin             <= '0;
              best_phase           <= '0;
              best_mag             <= '0;
              prn                  <= prn_first;
              bin                  <= '0;
              phase                <= '0;
              {cagen_t0, cagen_t1} <= tap_of(prn_first);
              nco_fcw              <= fcw_of(4'd0);
              cagen_rst            <= 1'b1;
              nco_rst              <= 1'b1;
              corr_clr             <= 1'b1;
              state                <= S_CONFIG;
            end else begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
          S_CONFIG: begin
            cnt   <= '0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (corr_valid) begin
              mag_r <= corr_mag;
              state <= S_EVAL;
            end else if (cnt == TIMEOUT_CYC - 32'd1) begin
              err   <= 1'b1;
              found <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          S_EVAL: begin
            if (mag_r >= thr_r) begin
              found     <= 1'b1;
              err       <= 1'b0;
              res_prn   <= prn;
              res_bin   <= bin;
              res_phase <= phase;
              res_mag   <= mag_r;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              if (mag_r > best_mag) begin
                best_prn   <= prn;
                best_bin   <= bin;
                best_phase <= phase;
                best_mag   <= mag_r;
              end
              state <= S_STEP;
            end
          end
          S_STEP: begin
            if (phase < 10'd1022) begin
              phase      <= phase + 10'd1;
              cagen_slip <= 1'b1;
              corr_clr   <= 1'b1;
              cnt        <= '0;
              state      <= S_WAIT;
            end else if (bin < LAST_BIN) begin
              bin       <= bin + 4'd1;
              phase     <= '0;
              nco_fcw   <= fcw_of(bin + 4'd1);
              cagen_rst <= 1'b1;
              nco_rst   <= 1'b1;
              corr_clr  <= 1'b1;
              state     <= S_CONFIG;
            end else if (prn < prn_last_r) begin
              prn                  <= prn + 6'd1;
              bin                  <= '0;
              phase                <= '0;
              {cagen_t0, cagen_t1} <= tap_of(prn + 6'd1);
              nco_fcw              <= fcw_of(4'd0);
              cagen_rst            <= 1'b1;
              nco_rst              <= 1'b1;
              corr_clr             <= 1'b1;
              state                <= S_CONFIG;
            end else begin
              found     <= 1'b0;
              err       <= 1'b0;
              res_prn   <= best_prn;
              res_bin   <= best_bin;
              res_phase <= best_phase;
              res_mag   <= best_mag;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
